reg_write_arbiter: RTL
======================

# reg_write_arbiter

Shares the single write port of the register bank between several requesters (ALU writeback, load unit, control path). Each cycle it grants at most one requester, round-robin, and drives the one-hot per-register `w_en` lines and the shared `d_in` bus of the `register` instances one cycle later. It has one clock domain and is the only writer of the register bank.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: data width; matches register `width`.
- `NREGS`, default 8: number of registers in the bank.
- `AW`, default 3: register address width; must satisfy `2**AW >= NREGS`.
- `MAX_BURST`, default 4: maximum consecutive grants under lock, 1..15. Only used with `REG_ARB_LOCK_EN`.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  bit i: requester i has a write pending.
- `lock`  in  NREQ  bit i: requester i asks to keep the grant. Ignored without `REG_ARB_LOCK_EN`.
- `addr`  in  NREQ*AW  flattened; slice i is `[i*AW +: AW]`.
- `data`  in  NREQ*WIDTH  flattened; slice i is `[i*WIDTH +: WIDTH]`.
- `ack`  out  NREQ  combinational one-hot grant; transfer i occurs on an edge with `req[i] & ack[i]`.
- `wr_en`  out  NREGS  registered one-hot; bit r drives `w_en` of register r.
- `wr_data`  out  WIDTH  registered; drives `d_in` of every register.
- `owner`  out  3  registered index of the last granted requester.
- `locked`  out  1  registered; high while in LOCKED.

## Operation
- Handshake:
  - A requester holds `req`, `addr` and `data` stable until it sees `ack` high at an edge.
  - `ack[i]` is only high when `req[i]` is high.
  - `ack` is all-zero while `rst` is high.
- Round-robin arbitration:
  - `ptr` holds the last granted index.
  - Priority order is `ptr+1, ptr+2, …` with wrap modulo NREQ.
  - On each transfer, `ptr` takes the granted index. `owner` mirrors `ptr`.
- FSM states:
  - IDLE: round-robin grant.
  - LOCKED: only `ptr` can be granted.
- Transitions:
  - IDLE→LOCKED on a transfer from i with `lock[i]` high, and only when `MAX_BURST > 1`. `burst` is set to 1.
  - In LOCKED, each further transfer increments `burst`.
  - LOCKED→IDLE at the first edge where any of these hold: `req[ptr]` is low, `lock[ptr]` is low, or a transfer makes `burst == MAX_BURST`.
  - When `req[ptr]` is low in LOCKED, no grant is given that cycle, even if other requesters are waiting. The lock owner's gaps cost one cycle.
- Write port:
  - On a transfer of (a, d), at the next edge `wr_en` becomes one-hot at bit a and `wr_data` becomes d.
  - Otherwise `wr_en` becomes 0 and `wr_data` holds its value.
- Out-of-range address: if `a >= NREGS`, the transfer is still acknowledged but `wr_en` stays 0.

## Timing
- Reset values: `wr_en`=0, `wr_data`=0, `owner`=NREQ-1 (so requester 0 has top priority), `locked`=0, state IDLE, `burst`=0.
- Reset wins over any simultaneous transfer. Reset mid-burst returns to IDLE and drops any pending write.
- Latency:
  - Transfer at edge k puts `wr_en`/`wr_data` valid during cycle k..k+1.
  - The register captures the value at edge k+1.
  - Read-after-write visibility is at edge k+1; there is no bypass.
- Throughput: one write per cycle, back to back.
- Two consecutive writes to the same register: the later one wins.
- A single requester with `req` held continuously is granted every cycle. No requester waits more than NREQ-1 grants in IDLE.

## Configuration
- `REG_ARB_LOCK_EN` defined:
  - `lock` and `MAX_BURST` are honoured.
  - The LOCKED state and `burst` counter exist.
- `REG_ARB_LOCK_EN` not defined:
  - No LOCKED state is built. The arbiter is pure round-robin.
  - `lock` is unused and `locked` is tied to 0.

## Test plan
- Reset then idle:
  - `rst` high 2 cycles with all `req` high → `ack`=0, `wr_en`=0, `owner`=3.
  - After release, the first grant goes to requester 0.
- Single write:
  - `req[2]`, `addr[2]`=5, `data[2]`=8'hA5 at edge k → `ack[2]` high before edge k.
  - `wr_en`=8'b0010_0000 and `wr_data`=8'hA5 during cycle k..k+1.
  - Register 5 reads 8'hA5 after edge k+1.
- Fairness: all four `req` held → grants 0,1,2,3,0,1 on consecutive edges; `wr_en` follows each `addr`.
- Lock burst (`REG_ARB_LOCK_EN`, MAX_BURST=4):
  - `req`=4'b1111, `lock[1]`=1, `ptr`=0 → requester 1 is granted 4 consecutive times with `locked`=1.
  - Then state returns to IDLE and requester 2 is granted next.
- Lock gap: locked owner drops `req` for one cycle → no `ack` that cycle, then state is IDLE and the next grant goes to `ptr+1`.
- Out-of-range address and mid-operation reset:
  - NREGS=6, `addr`=7 → `ack` high, `wr_en`=0.
  - `rst` asserted in the cycle after a transfer → `wr_en`=0 at the next edge and `wr_data`=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port; drives registered one-hot wr_en and wr_data.
// Define REG_ARB_LOCK_EN to build the LOCKED state and burst counter that honour `lock` and MAX_BURST.
module reg_write_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NREGS     = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*AW-1:0]      addr,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         ack,
    output logic [NREGS-1:0]        wr_en,
    output logic [WIDTH-1:0]        wr_data,
    output logic [2:0]              owner,
    output logic                    locked
);

    logic [2:0]       ptr_q, ptr_d;
    logic [NREGS-1:0] wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [2:0]       gnt_idx;
    logic             xfer;
    logic             rr_mode;
    logic [AW-1:0]    g_addr;
    logic [WIDTH-1:0] g_data;

`ifdef REG_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t     state_q, state_d;
    logic [3:0] burst_q, burst_d;
    logic       req_ptr, lock_ptr, lock_g;

    always_comb begin
        req_ptr  = 1'b0;
        lock_ptr = 1'b0;
        lock_g   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ptr_q == 3'(i)) begin
                req_ptr  = req[i];
                lock_ptr = lock[i];
            end
            if (gnt_idx == 3'(i)) lock_g = lock[i];
        end
    end

    assign rr_mode = (state_q == IDLE);
    assign locked  = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (xfer && lock_g && (MAX_BURST > 1)) begin
                    state_d = LOCKED;
                    burst_d = 4'd1;
                end
            end
            LOCKED: begin
                if (!req_ptr || !lock_ptr) begin
                    state_d = IDLE;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + 4'd1;
                    if (burst_q + 4'd1 == 4'(MAX_BURST)) begin
                        state_d = IDLE;
                        burst_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end
`else
    localparam int unsigned UNUSED_MAX_BURST = MAX_BURST;
    logic unused_lock;
    assign unused_lock = ^lock;
    assign rr_mode     = 1'b1;
    assign locked      = 1'b0;
`endif

    // Descending scan so the nearest requester after ptr is the last (winning) assignment.
    always_comb begin
        gnt_idx = ptr_q;
        xfer    = 1'b0;
        if (!rst) begin
            if (rr_mode) begin
                for (int unsigned k = NREQ; k >= 1; k--) begin
                    if (req[(32'(ptr_q) + k) % NREQ]) begin
                        gnt_idx = 3'((32'(ptr_q) + k) % NREQ);
                        xfer    = 1'b1;
                    end
                end
            end else begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (ptr_q == 3'(i) && req[i]) xfer = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ack    = '0;
        g_addr = '0;
        g_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == 3'(i)) begin
                ack[i] = xfer;
                g_addr = addr[i*AW +: AW];
                g_data = data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        wr_en_d = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            wr_en_d[r] = xfer && (g_addr == AW'(r));
        end
        wr_data_d = xfer ? g_data : wr_data_q;
        ptr_d     = xfer ? gnt_idx : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= 3'(NREQ - 1);
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign owner   = ptr_q;

endmodule
